// File: rtl/universal_counter_seq.sv
// Run-to-target initiator for universal_counter: drives clear/pause/mode/incr,
// freezes the counter on the target and reports done/err with the step count.
module universal_counter_seq #(
  parameter int MAX_STEPS = 32,
  parameter int STEP_W    = 8
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              start,
  input  logic [3:0]        tgt,
  input  logic              dir_up,
  input  logic              dec_mode,
  input  logic              clr_first,
  input  logic [3:0]        cnt_count,
  output logic              ctr_clear,
  output logic              ctr_pause,
  output logic              ctr_mode,
  output logic              ctr_incr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [STEP_W-1:0] steps
);

  typedef enum logic [2:0] {
    IDLE, CLR, CHECK, RUN, SETTLE, DONE, ERR
  } state_t;

  localparam logic [STEP_W-1:0] MAX_S = STEP_W'(MAX_STEPS);

  state_t            state, state_n;
  logic [3:0]        tgt_q;
  logic              up_q, dec_q;
  logic [STEP_W-1:0] steps_n;
  logic              mode_n, incr_n, accept;

  // Count value one step before t in the given direction and modulus.
  function automatic logic [3:0] pred_of(input logic [3:0] t, input logic up,
                                         input logic dec);
    logic [3:0] top;
    top = dec ? 4'd9 : 4'd15;
    if (up) pred_of = (t == 4'd0) ? top : t - 4'd1;
    else    pred_of = (t == top) ? 4'd0 : t + 4'd1;
  endfunction

  function automatic logic [STEP_W-1:0] sat_inc(input logic [STEP_W-1:0] s);
    sat_inc = (s >= MAX_S) ? MAX_S : s + 1'b1;
  endfunction

  always_comb begin
    state_n = state;
    steps_n = steps;
    mode_n  = ctr_mode;
    incr_n  = ctr_incr;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          mode_n  = dec_mode;
          incr_n  = dir_up;
          steps_n = '0;
          state_n = clr_first ? CLR : CHECK;
        end
      end
      CLR:   state_n = CHECK;
      CHECK: begin
        if (dec_q && (tgt_q > 4'd9)) state_n = ERR;
        else if (cnt_count == tgt_q)  state_n = DONE;
        else                          state_n = RUN;
      end
      RUN: begin
        // The counter takes its last step on the same edge that sees pred(tgt).
        steps_n = sat_inc(steps);
        if (cnt_count == pred_of(tgt_q, up_q, dec_q)) state_n = SETTLE;
        else if (steps_n == MAX_S)                    state_n = ERR;
      end
      SETTLE:    state_n = (cnt_count == tgt_q) ? DONE : ERR;
      DONE, ERR: state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  // Control and output registers: every output is a function of the next state.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state     <= IDLE;
      ctr_clear <= 1'b0;
      ctr_pause <= 1'b1;
      ctr_mode  <= 1'b0;
      ctr_incr  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      steps     <= '0;
    end else begin
      state     <= state_n;
      ctr_clear <= (state_n == CLR);
      ctr_pause <= (state_n != RUN);
      ctr_mode  <= mode_n;
      ctr_incr  <= incr_n;
      busy      <= (state_n != IDLE);
      done      <= (state_n == DONE);
      err       <= (state_n == ERR);
      steps     <= steps_n;
    end
  end

  // Command fields latched on acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      tgt_q <= tgt;
      up_q  <= dir_up;
      dec_q <= dec_mode;
    end
  end

endmodule

// File: tb/tb_universal_counter_seq.sv
// Scoreboard bench for universal_counter_seq driving a behavioural counter model,
// plus a second instance with a stuck count to exercise the step timeout.
module tb_universal_counter_seq;

  logic       clk = 1'b0;
  logic       clear, start, start4;
  logic [3:0] tgt;
  logic       dir_up, dec_mode, clr_first;
  logic [3:0] cnt;
  logic       load_en;
  logic [3:0] load_val;
  logic       ctr_clear, ctr_pause, ctr_mode, ctr_incr, busy, done, err;
  logic [7:0] steps;
  logic [3:0] cnt4;
  logic       ctr_clear4, ctr_pause4, ctr_mode4, ctr_incr4, busy4, done4, err4;
  logic [7:0] steps4;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_cyc = 0;

  typedef struct packed {
    logic        is_err;
    logic [7:0]  stp;
    logic [3:0]  fin;
    logic        lat_chk;
    logic [31:0] lat;
  } sb_t;

  sb_t exp_q[$];

  universal_counter_seq u_dut (
    .clk(clk), .clear(clear), .start(start), .tgt(tgt), .dir_up(dir_up),
    .dec_mode(dec_mode), .clr_first(clr_first), .cnt_count(cnt),
    .ctr_clear(ctr_clear), .ctr_pause(ctr_pause), .ctr_mode(ctr_mode),
    .ctr_incr(ctr_incr), .busy(busy), .done(done), .err(err), .steps(steps)
  );

  universal_counter_seq #(.MAX_STEPS(4), .STEP_W(8)) u_dut4 (
    .clk(clk), .clear(clear), .start(start4), .tgt(tgt), .dir_up(dir_up),
    .dec_mode(dec_mode), .clr_first(clr_first), .cnt_count(cnt4),
    .ctr_clear(ctr_clear4), .ctr_pause(ctr_pause4), .ctr_mode(ctr_mode4),
    .ctr_incr(ctr_incr4), .busy(busy4), .done(done4), .err(err4), .steps(steps4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign cnt4 = 4'd2;

  function automatic logic [3:0] nxt(input logic [3:0] c, input logic up, input logic dec);
    if (up) nxt = dec ? ((c >= 4'd9) ? 4'd0 : c + 4'd1) : c + 4'd1;
    else    nxt = (c == 4'd0) ? (dec ? 4'd9 : 4'd15) : c - 4'd1;
  endfunction

  always @(posedge clk) begin
    if (load_en)         cnt <= load_val;
    else if (ctr_clear)  cnt <= 4'd0;
    else if (!ctr_pause) cnt <= nxt(cnt, ctr_incr, ctr_mode);
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected outcome from the distance between start count and target.
  function automatic sb_t predict(input logic [3:0] c0, input logic [3:0] t, input logic up,
                                  input logic dec, input logic clr, input int max);
    sb_t e;
    logic [3:0] c;
    int d;
    c = clr ? 4'd0 : c0;
    e = '0;
    e.fin = t;
    if (dec && t > 4'd9) begin
      e.is_err = 1'b1;
    end else begin
      d = 0;
      while (c != t && d <= max) begin
        c = nxt(c, up, dec);
        d++;
      end
      if (d > max) begin
        e.is_err = 1'b1;
        e.stp = 8'(max);
      end else if (d > 0) begin
        e.stp = 8'(d);
        e.lat_chk = 1'b1;
        e.lat = 32'(d + 3 + (clr ? 1 : 0));
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!clear && (done || err)) begin
      if (exp_q.size() == 0) begin
        check_val("sb_unexpected_result", 1, 0);
      end else begin
        sb_t e;
        e = exp_q.pop_front();
        check_val("sb_done", done, !e.is_err);
        check_val("sb_err", err, e.is_err);
        check_val("sb_steps", steps, e.stp);
        if (!e.is_err) check_val("sb_landing", cnt, e.fin);
        if (e.lat_chk) check_val("sb_latency", cyc - start_cyc, e.lat);
      end
    end
  end

  task automatic check_reset(input string tag);
    check_val({tag, "_clear"}, ctr_clear, 0);
    check_val({tag, "_pause"}, ctr_pause, 1);
    check_val({tag, "_mode"}, ctr_mode, 0);
    check_val({tag, "_incr"}, ctr_incr, 1);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_done"}, done, 0);
    check_val({tag, "_err"}, err, 0);
    check_val({tag, "_steps"}, steps, 0);
  endtask

  task automatic run_cmd(input logic [3:0] c0, input logic [3:0] t, input logic up,
                         input logic dec, input logic clr, input logic dup,
                         input logic at_done);
    sb_t e;
    int clr_cnt = 0;
    logic dropped = 0, unstable = 0, seen = 0;
    @(negedge clk);
    load_en = 1; load_val = c0;
    @(negedge clk);
    load_en = 0;
    e = predict(c0, t, up, dec, clr, 32);
    exp_q.push_back(e);
    start_cyc = cyc;
    tgt = t; dir_up = up; dec_mode = dec; clr_first = clr; start = 1;
    @(negedge clk);
    start = 0;
    check_val("busy_rise", busy, 1);
    for (int i = 0; i < 60; i++) begin
      if (done || err) begin
        seen = 1;
        break;
      end
      if (ctr_clear) clr_cnt++;
      if (!ctr_pause) dropped = 1;
      if (ctr_mode != dec || ctr_incr != up) unstable = 1;
      if (dup && i == 1) begin
        start = 1; tgt = t ^ 4'hF; dir_up = ~up; dec_mode = ~dec; clr_first = 1;
      end else if (dup && i == 2) begin
        start = 0;
      end
      @(negedge clk);
    end
    check_val("result_within_budget", seen, 1);
    check_val("clr_pulses", clr_cnt, clr);
    check_val("mode_incr_stable", unstable, 0);
    if (e.stp == 0) check_val("pause_held", dropped, 0);
    if (at_done) start = 1;
    @(negedge clk);
    start = 0;
    check_val("busy_fall", busy, 0);
    @(negedge clk);
    check_val("steps_held", steps, e.stp);
    if (!e.is_err) check_val("count_holds", cnt, t);
  endtask

  initial begin
    clear = 1; start = 0; start4 = 0; tgt = 0; dir_up = 0; dec_mode = 0;
    clr_first = 0; load_en = 0; load_val = 0;
    #23;
    check_reset("rst");
    @(negedge clk);
    clear = 0;
    @(negedge clk);
    check_reset("idle");

    run_cmd(4'd9, 4'd5, 1, 0, 1, 0, 0);   // cleared first, binary up to 5
    run_cmd(4'd3, 4'd8, 0, 1, 0, 0, 0);   // decade down through the 0->9 wrap
    run_cmd(4'd7, 4'd7, 1, 0, 0, 0, 1);   // already on target, start with done
    run_cmd(4'd4, 4'd12, 1, 1, 0, 0, 0);  // illegal decade target
    run_cmd(4'd1, 4'd14, 0, 0, 0, 0, 0);  // binary down through 0->15
    run_cmd(4'd8, 4'd2, 1, 1, 0, 0, 0);   // decade up through 9->0
    run_cmd(4'd0, 4'd15, 1, 0, 0, 0, 0);  // longest binary run

    // Stuck counter on the small-budget instance: timeout error.
    begin
      logic seen4 = 0;
      int lat4 = 0;
      @(negedge clk);
      tgt = 4'd6; dir_up = 1; dec_mode = 0; clr_first = 0; start4 = 1;
      @(negedge clk);
      start4 = 0;
      lat4 = 1;
      for (int i = 0; i < 40; i++) begin
        if (err4 || done4) begin
          seen4 = 1;
          break;
        end
        @(negedge clk);
        lat4++;
      end
      check_val("to_seen", seen4, 1);
      check_val("to_err", err4, 1);
      check_val("to_done", done4, 0);
      check_val("to_steps", steps4, 4);
      check_val("to_pause", ctr_pause4, 1);
      check_val("to_latency", lat4, 6);
      @(negedge clk);
      check_val("to_busy_fall", busy4, 0);
    end

    // Asynchronous abort mid-RUN, then a command with a stray start while busy.
    @(negedge clk);
    load_en = 1; load_val = 4'd0;
    @(negedge clk);
    load_en = 0; tgt = 4'd10; dir_up = 1; dec_mode = 0; clr_first = 0; start = 1;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    check_val("abort_running", ctr_pause, 0);
    #2 clear = 1;
    #1 check_reset("abort");
    @(negedge clk);
    clear = 0;
    @(negedge clk);
    check_reset("post_abort");
    run_cmd(4'd2, 4'd6, 1, 0, 0, 1, 0);

    repeat (3) @(negedge clk);
    check_val("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
